// File: rtl/mem_banked_pkg.sv
// Shared types and helpers for the banked byte-lane memory interface.
// Helpers work on a row of up to MAX_LANES bytes. The caller passes the
// real lane count and truncates the result to its own width.
package mem_banked_pkg;

  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3} size_e;
  typedef enum logic {ST_IDLE = 1'b0, ST_RESP = 1'b1} port_st_e;

  localparam int MAX_LANES = 8;
  localparam int MAX_W     = 8 * MAX_LANES;

  typedef logic [MAX_LANES-1:0][7:0] row_t;

  // Unrotated byte mask covering 2^size bytes.
  function automatic logic [MAX_LANES-1:0] lane_mask(input logic [1:0] size);
    logic [MAX_LANES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LANES; i++)
      if (i < (1 << size)) m[i] = 1'b1;
    return m;
  endfunction

  // Rotate mask bits left by off, within the first lanes positions.
  function automatic logic [MAX_LANES-1:0] rot_mask(input logic [MAX_LANES-1:0] m,
                                                    input int off, input int lanes);
    logic [MAX_LANES-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_LANES; i++)
      for (int j = 0; j < MAX_LANES; j++)
        if (i < lanes && j == (i + off) % lanes) r[j] = m[i];
    return r;
  endfunction

  // Byte i of the input lands in lane (i + off) mod lanes.
  function automatic row_t rot_left(input row_t d, input int off, input int lanes);
    row_t r;
    r = '0;
    for (int i = 0; i < MAX_LANES; i++)
      for (int j = 0; j < MAX_LANES; j++)
        if (i < lanes && j == (i + off) % lanes) r[j] = d[i];
    return r;
  endfunction

  // Inverse of rot_left: output byte i comes from lane (i + off) mod lanes.
  function automatic row_t rot_right(input row_t d, input int off, input int lanes);
    row_t r;
    r = '0;
    for (int i = 0; i < MAX_LANES; i++)
      for (int j = 0; j < MAX_LANES; j++)
        if (i < lanes && j == (i + off) % lanes) r[i] = d[j];
    return r;
  endfunction

  // Keep 2^size bytes, then sign- or zero-extend to the full row.
  function automatic logic [MAX_W-1:0] extend(input row_t d, input logic [1:0] size,
                                              input logic uns);
    logic [MAX_W-1:0] v, r;
    logic s;
    v = d;
    s = 1'b0;
    for (int i = 0; i < MAX_W; i++)
      if (i == 8 * (1 << size) - 1) s = v[i];
    for (int i = 0; i < MAX_W; i++)
      r[i] = (i < 8 * (1 << size)) ? v[i] : (s & ~uns);
    return r;
  endfunction

endpackage

// File: rtl/mem_interface_banked_ram.sv
// byte_lane_ram: one byte lane, DEPTH x 8, true dual port.
// Each port has its own en/we. Reads are read-first with one cycle of
// latency. When both ports write the same row, port B wins.
// Ports: clk; a_/b_ en, we, addr, wdata, rdata.
module byte_lane_ram #(
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          a_en,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [7:0]    a_wdata,
  output logic [7:0]    a_rdata,
  input  logic          b_en,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [7:0]    b_wdata,
  output logic [7:0]    b_rdata
);
  logic [7:0] mem [DEPTH];

  // The reads sample the old contents. Port B's write comes last, so it
  // takes precedence when both ports write the same row.
  always_ff @(posedge clk) begin
    if (a_en) a_rdata <= mem[a_addr];
    if (b_en) b_rdata <= mem[b_addr];
    if (a_en && a_we) mem[a_addr] <= a_wdata;
    if (b_en && b_we) mem[b_addr] <= b_wdata;
  end
endmodule

// File: rtl/mem_interface_banked.sv
// mem_interface_banked: dual-port, byte-lane banked memory.
// Port A serves fetch and loader writes; port B serves load/store.
// A misaligned access is split across two rows: lanes below the byte
// offset use row+1. Each port has a valid/ready request and a valid/ready
// response. The response follows one cycle after accept and is held under
// backpressure. Loads are sign- or zero-extended. Bounds, illegal size and
// (optionally) misalignment give err=1 with no write.
// Ports: clk, rst_n; per port x in {a,b}: x_req_valid/x_req_ready,
//   x_addr, x_we, x_size, x_unsigned, x_wdata, x_rsp_valid/x_rsp_ready,
//   x_rdata, x_rsp_err.
module mem_interface_banked
  import mem_banked_pkg::*;
#(
  parameter int LANES         = 4,
  parameter int DEPTH         = 1024,
  parameter int ADDR_W        = 32,
  parameter int MISALIGN_TRAP = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                a_req_valid,
  output logic                a_req_ready,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic                a_we,
  input  logic [1:0]          a_size,
  input  logic                a_unsigned,
  input  logic [8*LANES-1:0]  a_wdata,
  output logic                a_rsp_valid,
  input  logic                a_rsp_ready,
  output logic [8*LANES-1:0]  a_rdata,
  output logic                a_rsp_err,
  input  logic                b_req_valid,
  output logic                b_req_ready,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic                b_we,
  input  logic [1:0]          b_size,
  input  logic                b_unsigned,
  input  logic [8*LANES-1:0]  b_wdata,
  output logic                b_rsp_valid,
  input  logic                b_rsp_ready,
  output logic [8*LANES-1:0]  b_rdata,
  output logic                b_rsp_err
);
  localparam int W     = 8 * LANES;
  localparam int OFF_W = $clog2(LANES);
  localparam int ROW_W = $clog2(DEPTH);
  localparam logic [63:0] CAP = 64'(LANES) * 64'(DEPTH);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [1:0]        size;
    logic              uns;
    logic [W-1:0]      wdata;
  } req_t;

  req_t [1:0]                        req;
  logic [1:0]                        rsp_ready, req_ready, rsp_valid, rsp_err;
  logic [1:0][W-1:0]                 rdata;
  logic [1:0][LANES-1:0]             lane_en;
  logic [1:0]                        lane_we;
  logic [1:0][LANES-1:0][ROW_W-1:0]  lane_row;
  logic [1:0][LANES-1:0][7:0]        lane_wd, lane_q;

  assign req[0] = '{a_req_valid, a_addr, a_we, a_size, a_unsigned, a_wdata};
  assign req[1] = '{b_req_valid, b_addr, b_we, b_size, b_unsigned, b_wdata};
  assign rsp_ready = {b_rsp_ready, a_rsp_ready};

  assign a_req_ready = req_ready[0];
  assign a_rsp_valid = rsp_valid[0];
  assign a_rdata     = rdata[0];
  assign a_rsp_err   = rsp_err[0];
  assign b_req_ready = req_ready[1];
  assign b_rsp_valid = rsp_valid[1];
  assign b_rdata     = rdata[1];
  assign b_rsp_err   = rsp_err[1];

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [OFF_W-1:0]      off, off_q;
    logic [ROW_W-1:0]      row;
    logic [ADDR_W:0]       last;
    logic                  err, acc, go;
    logic [1:0]            size_q;
    logic                  uns_q, err_q, rd_q;
    logic [LANES-1:0]      mrot;
    logic [LANES-1:0][7:0] wrot;
    logic [W-1:0]          ext;
    port_st_e              st_q, st_d;

    assign off  = req[p].addr[OFF_W-1:0];
    assign row  = ROW_W'(req[p].addr >> OFF_W);
    assign last = {1'b0, req[p].addr} + ((ADDR_W+1)'(1) << req[p].size) - (ADDR_W+1)'(1);

    // Out of range (no wrap to row 0), wider than a row, or trapped misalignment.
    assign err = (64'(last) >= CAP)
              || ((32'd1 << req[p].size) > 32'(LANES))
              || ((MISALIGN_TRAP != 0)
                  && ((req[p].addr[2:0] & (3'(32'd1 << req[p].size) - 3'd1)) != 3'd0));

    assign req_ready[p] = !rsp_valid[p] || rsp_ready[p];
    assign acc          = req[p].valid && req_ready[p];
    assign go           = acc && !err;

    // Lanes are enabled only on a good accept, so RAM outputs stay put during a hold.
    assign mrot = LANES'(rot_mask(lane_mask(req[p].size), int'(off), LANES));
    assign wrot = W'(rot_left(row_t'(MAX_W'(req[p].wdata)), int'(off), LANES));
    assign lane_en[p] = go ? mrot : '0;
    assign lane_we[p] = req[p].we;
    assign lane_wd[p] = wrot;

    for (genvar i = 0; i < LANES; i++) begin : g_row
      assign lane_row[p][i] = (OFF_W'(i) < off) ? row + ROW_W'(1) : row;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st_q <= ST_IDLE;
      else        st_q <= st_d;
    end

    always_comb begin
      st_d = st_q;
      case (st_q)
        ST_IDLE: if (acc) st_d = ST_RESP;
        ST_RESP: if (rsp_ready[p]) st_d = acc ? ST_RESP : ST_IDLE;
        default: st_d = ST_IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        off_q  <= '0;
        size_q <= '0;
        uns_q  <= 1'b0;
        err_q  <= 1'b0;
        rd_q   <= 1'b0;
      end else if (acc) begin
        off_q  <= off;
        size_q <= req[p].size;
        uns_q  <= req[p].uns;
        err_q  <= err;
        rd_q   <= !req[p].we && !err;
      end
    end

    assign ext = W'(extend(rot_right(row_t'(MAX_W'(lane_q[p])), int'(off_q), LANES),
                           size_q, uns_q));

    assign rsp_valid[p] = (st_q == ST_RESP);
    assign rsp_err[p]   = err_q;
    // Stores, errors and the post-reset state all read as zero.
    assign rdata[p]     = rd_q ? ext : '0;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    byte_lane_ram #(.DEPTH(DEPTH)) u_ram (
      .clk     (clk),
      .a_en    (lane_en[0][i]),
      .a_we    (lane_we[0]),
      .a_addr  (lane_row[0][i]),
      .a_wdata (lane_wd[0][i]),
      .a_rdata (lane_q[0][i]),
      .b_en    (lane_en[1][i]),
      .b_we    (lane_we[1]),
      .b_addr  (lane_row[1][i]),
      .b_wdata (lane_wd[1][i]),
      .b_rdata (lane_q[1][i])
    );
  end
endmodule

// File: tb/tb_mem_interface_banked.sv
module tb_mem_interface_banked;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // dut: split-mode instance, 4 lanes x 16 rows (64 bytes)
  logic        a_req_valid, a_req_ready, a_we, a_unsigned, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [1:0]  a_size;
  logic        b_req_valid, b_req_ready, b_we, b_unsigned, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [1:0]  b_size;
  // dut_t: trap-mode instance
  logic        ta_req_valid, ta_req_ready, ta_we, ta_unsigned, ta_rsp_valid, ta_rsp_ready, ta_rsp_err;
  logic [31:0] ta_addr, ta_wdata, ta_rdata;
  logic [1:0]  ta_size;
  logic        tb_req_valid, tb_req_ready, tb_we, tb_unsigned, tb_rsp_valid, tb_rsp_ready, tb_rsp_err;
  logic [31:0] tb_addr, tb_wdata, tb_rdata;
  logic [1:0]  tb_size;

  int checks = 0;
  int errors = 0;

  mem_interface_banked #(.LANES(4), .DEPTH(16), .ADDR_W(32), .MISALIGN_TRAP(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_addr(a_addr), .a_we(a_we),
    .a_size(a_size), .a_unsigned(a_unsigned), .a_wdata(a_wdata), .a_rsp_valid(a_rsp_valid),
    .a_rsp_ready(a_rsp_ready), .a_rdata(a_rdata), .a_rsp_err(a_rsp_err),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_addr(b_addr), .b_we(b_we),
    .b_size(b_size), .b_unsigned(b_unsigned), .b_wdata(b_wdata), .b_rsp_valid(b_rsp_valid),
    .b_rsp_ready(b_rsp_ready), .b_rdata(b_rdata), .b_rsp_err(b_rsp_err));

  mem_interface_banked #(.LANES(4), .DEPTH(16), .ADDR_W(32), .MISALIGN_TRAP(1)) dut_t (
    .clk(clk), .rst_n(rst_n),
    .a_req_valid(ta_req_valid), .a_req_ready(ta_req_ready), .a_addr(ta_addr), .a_we(ta_we),
    .a_size(ta_size), .a_unsigned(ta_unsigned), .a_wdata(ta_wdata), .a_rsp_valid(ta_rsp_valid),
    .a_rsp_ready(ta_rsp_ready), .a_rdata(ta_rdata), .a_rsp_err(ta_rsp_err),
    .b_req_valid(tb_req_valid), .b_req_ready(tb_req_ready), .b_addr(tb_addr), .b_we(tb_we),
    .b_size(tb_size), .b_unsigned(tb_unsigned), .b_wdata(tb_wdata), .b_rsp_valid(tb_rsp_valid),
    .b_rsp_ready(tb_rsp_ready), .b_rdata(tb_rdata), .b_rsp_err(tb_rsp_err));

  // One request on dut port B. Entered and left at posedge+1; returns the response.
  task automatic do_b(input logic we, input logic [31:0] addr, input logic [1:0] size,
                      input logic uns, input logic [31:0] wd,
                      output logic vl, output logic er, output logic [31:0] rd);
    b_req_valid = 1'b1; b_we = we; b_addr = addr; b_size = size; b_unsigned = uns; b_wdata = wd;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    vl = b_rsp_valid; er = b_rsp_err; rd = b_rdata;
  endtask

  task automatic do_a(input logic we, input logic [31:0] addr, input logic [1:0] size,
                      input logic uns, input logic [31:0] wd,
                      output logic vl, output logic er, output logic [31:0] rd);
    a_req_valid = 1'b1; a_we = we; a_addr = addr; a_size = size; a_unsigned = uns; a_wdata = wd;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    vl = a_rsp_valid; er = a_rsp_err; rd = a_rdata;
  endtask

  task automatic do_t(input logic we, input logic [31:0] addr, input logic [1:0] size,
                      input logic uns, input logic [31:0] wd,
                      output logic vl, output logic er, output logic [31:0] rd);
    tb_req_valid = 1'b1; tb_we = we; tb_addr = addr; tb_size = size; tb_unsigned = uns; tb_wdata = wd;
    @(posedge clk); #1;
    tb_req_valid = 1'b0;
    vl = tb_rsp_valid; er = tb_rsp_err; rd = tb_rdata;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({b_rsp_valid, b_rsp_err, b_rdata} !== 34'h0) begin
      errors++; $display("FAIL reset_b got v%b e%b d%h exp 0 0 0", b_rsp_valid, b_rsp_err, b_rdata);
    end
    checks++;
    if ({a_rsp_valid, a_rsp_err, a_rdata, tb_rsp_valid, tb_rdata} !== 67'h0) begin
      errors++; $display("FAIL reset_a_t got v%b d%h tv%b td%h exp 0", a_rsp_valid, a_rdata, tb_rsp_valid, tb_rdata);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({a_req_ready, b_req_ready, tb_req_ready} !== 3'b111) begin
      errors++; $display("FAIL reset_ready got %b%b%b exp 111", a_req_ready, b_req_ready, tb_req_ready);
    end
  endtask

  task automatic test_aligned();
    logic v, e; logic [31:0] d;
    do_b(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, v, e, d);
    checks++;
    if ({v, e, d} !== {1'b1, 1'b0, 32'h0}) begin
      errors++; $display("FAIL aligned_store got v%b e%b d%h exp 1 0 0", v, e, d);
    end
    do_b(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, v, e, d);
    checks++;
    if ({v, e, d} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
      errors++; $display("FAIL aligned_load got v%b e%b d%h exp 1 0 deadbeef", v, e, d);
    end
  endtask

  task automatic test_misaligned();
    logic v, e; logic [31:0] d;
    do_b(1'b1, 32'h13, 2'd1, 1'b0, 32'h0000A1B2, v, e, d);
    checks++;
    if ({v, e} !== 2'b10) begin errors++; $display("FAIL mis_store got v%b e%b exp 1 0", v, e); end
    do_b(1'b0, 32'h13, 2'd1, 1'b0, 32'h0, v, e, d);
    checks++;
    if ({e, d} !== {1'b0, 32'hFFFFA1B2}) begin errors++; $display("FAIL mis_half_s got e%b d%h exp 0 ffffa1b2", e, d); end
    do_b(1'b0, 32'h14, 2'd0, 1'b1, 32'h0, v, e, d);
    checks++;
    if (d !== 32'h000000A1) begin errors++; $display("FAIL mis_byte14_u got %h exp 000000a1", d); end
    do_b(1'b0, 32'h13, 2'd0, 1'b0, 32'h0, v, e, d);
    checks++;
    if (d !== 32'hFFFFFFB2) begin errors++; $display("FAIL mis_byte13_s got %h exp ffffffb2", d); end
    do_b(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, v, e, d);
    checks++;
    if (d !== 32'hB2ADBEEF) begin errors++; $display("FAIL mis_word10 got %h exp b2adbeef", d); end
  endtask

  task automatic test_bounds();
    logic v, e; logic [31:0] d;
    do_b(1'b1, 32'h0, 2'd2, 1'b0, 32'h11223344, v, e, d);
    do_b(1'b1, 32'd62, 2'd2, 1'b0, 32'hCAFEBABE, v, e, d);
    checks++;
    if ({v, e, d} !== {1'b1, 1'b1, 32'h0}) begin errors++; $display("FAIL bound_word62 got v%b e%b d%h exp 1 1 0", v, e, d); end
    do_b(1'b0, 32'h0, 2'd2, 1'b0, 32'h0, v, e, d);
    checks++;
    if ({e, d} !== {1'b0, 32'h11223344}) begin errors++; $display("FAIL bound_row0 got e%b d%h exp 0 11223344", e, d); end
    do_b(1'b1, 32'd63, 2'd0, 1'b0, 32'h0000007E, v, e, d);
    checks++;
    if ({v, e} !== 2'b10) begin errors++; $display("FAIL bound_byte63_st got v%b e%b exp 1 0", v, e); end
    do_b(1'b0, 32'd63, 2'd0, 1'b0, 32'h0, v, e, d);
    checks++;
    if ({e, d} !== {1'b0, 32'h0000007E}) begin errors++; $display("FAIL bound_byte63_ld got e%b d%h exp 0 7e", e, d); end
    do_b(1'b0, 32'h0, 2'd3, 1'b0, 32'h0, v, e, d);
    checks++;
    if ({v, e, d} !== {1'b1, 1'b1, 32'h0}) begin errors++; $display("FAIL bound_dword got v%b e%b d%h exp 1 1 0", v, e, d); end
  endtask

  task automatic test_back_to_back();
    logic v, e; logic [31:0] d;
    do_b(1'b1, 32'h28, 2'd2, 1'b0, 32'h0BADF00D, v, e, d);
    do_b(1'b1, 32'h2C, 2'd2, 1'b0, 32'h12345678, v, e, d);
    do_b(1'b0, 32'h28, 2'd2, 1'b0, 32'h0, v, e, d);
    checks++;
    if ({v, d} !== {1'b1, 32'h0BADF00D}) begin errors++; $display("FAIL b2b_ld28 got v%b d%h exp 1 0badf00d", v, d); end
    do_b(1'b0, 32'h2C, 2'd2, 1'b0, 32'h0, v, e, d);
    checks++;
    if ({v, d} !== {1'b1, 32'h12345678}) begin errors++; $display("FAIL b2b_ld2c got v%b d%h exp 1 12345678", v, d); end
    do_b(1'b0, 32'h2A, 2'd2, 1'b0, 32'h0, v, e, d);
    checks++;
    if (d !== 32'h56780BAD) begin errors++; $display("FAIL b2b_split2a got %h exp 56780bad", d); end
    do_a(1'b0, 32'h2A, 2'd2, 1'b0, 32'h0, v, e, d);
    checks++;
    if ({v, e, d} !== {1'b1, 1'b0, 32'h56780BAD}) begin errors++; $display("FAIL a_split2a got v%b e%b d%h exp 1 0 56780bad", v, e, d); end
  endtask

  task automatic test_trap();
    logic v, e; logic [31:0] d;
    do_t(1'b1, 32'h20, 2'd2, 1'b0, 32'h01020304, v, e, d);
    checks++;
    if ({v, e} !== 2'b10) begin errors++; $display("FAIL trap_aligned_st got v%b e%b exp 1 0", v, e); end
    do_t(1'b1, 32'h21, 2'd2, 1'b0, 32'hFFFFFFFF, v, e, d);
    checks++;
    if ({v, e, d} !== {1'b1, 1'b1, 32'h0}) begin errors++; $display("FAIL trap_mis_st got v%b e%b d%h exp 1 1 0", v, e, d); end
    do_t(1'b0, 32'h20, 2'd2, 1'b0, 32'h0, v, e, d);
    checks++;
    if ({e, d} !== {1'b0, 32'h01020304}) begin errors++; $display("FAIL trap_unchanged got e%b d%h exp 0 01020304", e, d); end
    do_t(1'b0, 32'h21, 2'd1, 1'b0, 32'h0, v, e, d);
    checks++;
    if ({e, d} !== {1'b1, 32'h0}) begin errors++; $display("FAIL trap_mis_half got e%b d%h exp 1 0", e, d); end
    do_t(1'b0, 32'h21, 2'd0, 1'b1, 32'h0, v, e, d);
    checks++;
    if ({e, d} !== {1'b0, 32'h03}) begin errors++; $display("FAIL trap_byte21 got e%b d%h exp 0 03", e, d); end
  endtask

  task automatic test_backpressure();
    logic v, e; logic [31:0] d;
    b_rsp_ready = 1'b0;
    do_b(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, v, e, d);
    checks++;
    if ({v, d} !== {1'b1, 32'hB2ADBEEF}) begin errors++; $display("FAIL bp_first got v%b d%h exp 1 b2adbeef", v, d); end
    b_req_valid = 1'b1; b_we = 1'b0; b_addr = 32'h0; b_size = 2'd2; b_unsigned = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({b_rsp_valid, b_req_ready, b_rdata} !== {1'b1, 1'b0, 32'hB2ADBEEF}) begin
        errors++; $display("FAIL bp_hold%0d got v%b r%b d%h exp 1 0 b2adbeef", k, b_rsp_valid, b_req_ready, b_rdata);
      end
    end
    b_rsp_ready = 1'b1;
    #1;
    checks++;
    if (b_req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", b_req_ready); end
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    checks++;
    if ({b_rsp_valid, b_rdata} !== {1'b1, 32'h11223344}) begin errors++; $display("FAIL bp_next got v%b d%h exp 1 11223344", b_rsp_valid, b_rdata); end
    @(posedge clk); #1;
    checks++;
    if (b_rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_idle got %b exp 0", b_rsp_valid); end
  endtask

  task automatic test_collision();
    logic v, e; logic [31:0] d;
    a_req_valid = 1'b1; a_we = 1'b0; a_addr = 32'h14; a_size = 2'd0; a_unsigned = 1'b1;
    b_req_valid = 1'b1; b_we = 1'b1; b_addr = 32'h14; b_size = 2'd0; b_wdata = 32'h55;
    @(posedge clk); #1;
    a_req_valid = 1'b0; b_req_valid = 1'b0;
    checks++;
    if ({a_rsp_valid, a_rdata, b_rsp_valid, b_rdata} !== {1'b1, 32'hA1, 1'b1, 32'h0}) begin
      errors++; $display("FAIL coll_rd_old got a%h b%h exp a1 0", a_rdata, b_rdata);
    end
    do_a(1'b0, 32'h14, 2'd0, 1'b1, 32'h0, v, e, d);
    checks++;
    if (d !== 32'h55) begin errors++; $display("FAIL coll_new got %h exp 55", d); end
    a_req_valid = 1'b1; a_we = 1'b1; a_addr = 32'h14; a_size = 2'd0; a_wdata = 32'h66;
    b_req_valid = 1'b1; b_we = 1'b1; b_addr = 32'h14; b_size = 2'd0; b_wdata = 32'h77;
    @(posedge clk); #1;
    a_req_valid = 1'b0; b_req_valid = 1'b0;
    do_a(1'b0, 32'h14, 2'd0, 1'b1, 32'h0, v, e, d);
    checks++;
    if (d !== 32'h77) begin errors++; $display("FAIL coll_ww got %h exp 77", d); end
    // Reset while a response is pending
    do_b(1'b0, 32'h14, 2'd0, 1'b1, 32'h0, v, e, d);
    checks++;
    if ({v, d} !== {1'b1, 32'h77}) begin errors++; $display("FAIL rst_pre got v%b d%h exp 1 77", v, d); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({b_rsp_valid, b_rdata} !== 33'h0) begin errors++; $display("FAIL rst_async got v%b d%h exp 0 0", b_rsp_valid, b_rdata); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({b_req_ready, b_rsp_valid} !== 2'b10) begin errors++; $display("FAIL rst_after got r%b v%b exp 1 0", b_req_ready, b_rsp_valid); end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    a_req_valid = 0; a_we = 0; a_addr = 0; a_size = 0; a_unsigned = 0; a_wdata = 0; a_rsp_ready = 1;
    b_req_valid = 0; b_we = 0; b_addr = 0; b_size = 0; b_unsigned = 0; b_wdata = 0; b_rsp_ready = 1;
    ta_req_valid = 0; ta_we = 0; ta_addr = 0; ta_size = 0; ta_unsigned = 0; ta_wdata = 0; ta_rsp_ready = 1;
    tb_req_valid = 0; tb_we = 0; tb_addr = 0; tb_size = 0; tb_unsigned = 0; tb_wdata = 0; tb_rsp_ready = 1;
    test_reset();
    test_aligned();
    test_misaligned();
    test_bounds();
    test_back_to_back();
    test_trap();
    test_backpressure();
    test_collision();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_interface_banked.md
Name: mem_interface_banked

Overview:
- Parametrised dual-port byte-lane banked memory interface; successor to the fixed 4-lane instruction/data memory interface.
- Port A serves instruction fetch (and debug/loader writes); port B serves load/store.
- Supports misaligned accesses by row-splitting across lanes, plus an optional trap mode.
- Adds valid/ready request and response handshakes, response backpressure, load sign/zero extension, and bounds/alignment error responses.

Parameters:
- LANES, 4, byte lanes per row; power of two, 4 or 8.
- DEPTH, 1024, rows per lane.
- ADDR_W, 32, byte-address width.
- MISALIGN_TRAP, 0, behaviour for a non-size-aligned access: 0 = perform a split-row access; 1 = return an error response with no write.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- a_req_valid / b_req_valid  in  1  request valid.
- a_req_ready / b_req_ready  out  1  request accept.
- a_addr / b_addr  in  ADDR_W  byte address.
- a_we / b_we  in  1  1 = store, 0 = load.
- a_size / b_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = dword (legal only when LANES=8).
- a_unsigned / b_unsigned  in  1  load zero-extend (1) or sign-extend (0).
- a_wdata / b_wdata  in  8*LANES  store data, LSB-aligned.
- a_rsp_valid / b_rsp_valid  out  1  response valid.
- a_rsp_ready / b_rsp_ready  in  1  response accept.
- a_rdata / b_rdata  out  8*LANES  load data, extended to full width.
- a_rsp_err / b_rsp_err  out  1  access error.

Behaviour:
- Reset (async, rst_n low): rsp_valid=0, rsp_err=0, internal offset/size registers cleared, so rdata reads 0.
  - req_ready is 1 from the first cycle after reset.
  - Memory contents are not reset.
- Handshake, each port independent: req_ready = !rsp_valid || rsp_ready.
  - Request is accepted on req_valid && req_ready.
  - Exactly one response per accepted request, presented the cycle after accept.
  - Full throughput is one request per cycle per port.
- Backpressure: while rsp_valid && !rsp_ready, rdata and rsp_err are held stable.
  - Lane RAM enables are asserted only on accept, so RAM outputs do not change during a hold.
- Lane addressing, with off = addr[log2(LANES)-1:0] and row = addr >> log2(LANES):
  - lane i uses row+1 when i < off, otherwise row.
  - Write data and byte mask (2^size bytes) are rotated left by off lanes.
  - Read data is rotated right by the registered off, truncated to 2^size bytes, then sign- or zero-extended.
- Store response: rsp_valid=1, rdata=0.
- Error conditions; an error access performs no write, enables no lane, and returns rdata=0 with err=1:
  - last byte addr + 2^size - 1 ≥ LANES*DEPTH (no wrap to row 0);
  - size=3 when LANES=4;
  - MISALIGN_TRAP=1 and addr mod 2^size ≠ 0.
- Port collision on the same lane and same row in the same cycle:
  - both write: port B data is stored;
  - one reads, the other writes: the read returns old data (read-first).
- Reset asserted mid-operation: pending responses are dropped and rsp_valid clears immediately; no partial-write guarantee for the cycle reset is asserted.
- Per-port state machine: IDLE (no response pending) → RESP on accept.
  - RESP → RESP on rsp_ready with a new accept.
  - RESP → IDLE on rsp_ready without a new accept.
  - RESP → RESP (hold) on !rsp_ready.

Decomposition:
- Package mem_banked_pkg: size encoding enum (SZ_B, SZ_H, SZ_W, SZ_D), lane-mask function, rotate functions, extend function.
- Sub-module byte_lane_ram: true dual-port, DEPTH×8, per-port en/we, read-first, one-cycle read latency.
  - Instantiated LANES times by a generate loop.
- Per-port request/response control is a generate loop over the two ports.

Test Plan:
- Aligned word (LANES=4): B stores 0xDEADBEEF at 0x10, then loads word from 0x10 → rdata=0xDEADBEEF one cycle after accept, err=0.
- Misaligned half (MISALIGN_TRAP=0): store 0xA1B2 at 0x13, then signed half load from 0x13 → 0xFFFFA1B2.
  - Byte 0x14 reads 0xA1 (unsigned byte load).
- Trap mode (MISALIGN_TRAP=1): word store at 0x21 → err=1, rdata=0; subsequent load from 0x20 shows the memory unchanged.
- Bounds: word access at LANES*DEPTH-2 → err=1 and no write to row 0.
  - Byte access at LANES*DEPTH-1 → ok.
- Backpressure: hold b_rsp_ready=0 for 3 cycles after a load.
  - b_req_ready=0 and rdata stable throughout.
  - On release, the next request is accepted in the same cycle the response is taken.
- Collision and reset: A loads and B stores 0x55 to the same byte in the same cycle → A returns old value.
  - Assert rst_n low mid-response → rsp_valid=0 asynchronously.
